// File: rtl/prog_seq_fsm.sv
// Programmable N-state sequencer.
// A per-state next-state table and timeout table are written while idle; the sequence then
// advances on debounced per-state request inputs. State 0 is IDLE, states 1..N_STATES are active.
module prog_seq_fsm #(
    parameter int unsigned N_STATES = 5,
    parameter int unsigned SW       = 4,
    parameter int unsigned TW       = 8,
    parameter int unsigned DEB      = 2
) (
    input  logic                i_clk,
    input  logic                i_rst_n,
    input  logic                i_cfg_we,
    input  logic [SW-1:0]       i_cfg_addr,
    input  logic [SW-1:0]       i_cfg_next,
    input  logic [TW-1:0]       i_cfg_tmo,
    input  logic                i_ok,
    input  logic                i_abort,
    input  logic [N_STATES-1:0] i_in,
    output logic [SW-1:0]       o_out_state,
    output logic [N_STATES-1:0] o_out,
    output logic                o_busy,
    output logic                o_done,
    output logic                o_timeout,
    output logic                o_cfg_err
);

    // Tables are sized to the full code space so any state code indexes safely;
    // entries above N_STATES are never written and stay zero.
    localparam int unsigned NCODES = 2 ** SW;
    localparam int unsigned DW     = 4;

    localparam logic [SW-1:0] ST_IDLE  = '0;
    localparam logic [SW-1:0] ST_FIRST = SW'(1);
    localparam logic [SW-1:0] ST_MAX   = SW'(N_STATES);
    localparam logic [DW-1:0] DEB_LAST = DW'(DEB - 1);
    localparam logic [TW-1:0] TMO_SAT  = '1;

    // Default ring: k -> k+1, last state wraps to 1.
    function automatic logic [SW-1:0] ring_next(input int unsigned k);
        if (k >= 1 && k < N_STATES) begin
            return SW'(k + 1);
        end else if (k == N_STATES) begin
            return ST_FIRST;
        end else begin
            return '0;
        end
    endfunction

    logic [SW-1:0]       r_state;
    logic [DW-1:0]       r_deb_cnt;
    logic [TW-1:0]       r_tmo_cnt;
    logic                r_done;
    logic                r_timeout;
    logic                r_cfg_err;
    logic [N_STATES-1:0] r_out;
    logic [SW-1:0]       r_next_tbl [NCODES];
    logic [TW-1:0]       r_tmo_tbl  [NCODES];

    logic [SW-1:0]       w_state_d;
    logic [DW-1:0]       w_deb_cnt_d;
    logic [TW-1:0]       w_tmo_cnt_d;
    logic                w_done_d;
    logic                w_timeout_d;
    logic                w_cfg_ok;
    logic                w_cfg_err_d;
    logic [N_STATES-1:0] w_out_d;
    logic [NCODES-1:0]   w_in_ext;
    logic                w_in_cur;
    logic                w_active;
    logic [SW-1:0]       w_next_cur;
    logic [TW-1:0]       w_tmo_cur;

    // Shift request bits up by one so bit k lines up with state code k.
    assign w_in_ext   = NCODES'({i_in, 1'b0});
    assign w_in_cur   = w_in_ext[r_state];
    assign w_active   = (r_state != ST_IDLE) && (r_state <= ST_MAX);
    assign w_next_cur = r_next_tbl[r_state];
    assign w_tmo_cur  = r_tmo_tbl[r_state];

    assign w_cfg_ok    = i_cfg_we && (r_state == ST_IDLE) && (i_cfg_addr != '0)
                         && (i_cfg_addr <= ST_MAX) && (i_cfg_next <= ST_MAX);
    assign w_cfg_err_d = i_cfg_we && !w_cfg_ok;

    // State register plus counters and registered pulse outputs.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state   <= ST_IDLE;
            r_deb_cnt <= '0;
            r_tmo_cnt <= '0;
            r_done    <= 1'b0;
            r_timeout <= 1'b0;
            r_cfg_err <= 1'b0;
            r_out     <= '0;
        end else begin
            r_state   <= w_state_d;
            r_deb_cnt <= w_deb_cnt_d;
            r_tmo_cnt <= w_tmo_cnt_d;
            r_done    <= w_done_d;
            r_timeout <= w_timeout_d;
            r_cfg_err <= w_cfg_err_d;
            r_out     <= w_out_d;
        end
    end

    // Configuration tables: reload the default ring on reset, accept writes only when idle.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int unsigned k = 0; k < NCODES; k++) begin
                r_next_tbl[k] <= ring_next(k);
                r_tmo_tbl[k]  <= '0;
            end
        end else if (w_cfg_ok) begin
            r_next_tbl[i_cfg_addr] <= i_cfg_next;
            r_tmo_tbl[i_cfg_addr]  <= i_cfg_tmo;
        end
    end

    // Next-state logic: abort, then advance, then timeout, else hold and count.
    always_comb begin
        w_state_d   = r_state;
        w_deb_cnt_d = '0;
        w_tmo_cnt_d = '0;
        w_done_d    = 1'b0;
        w_timeout_d = 1'b0;
        if (r_state == ST_IDLE) begin
            if (i_ok && !i_abort) begin
                w_state_d = ST_FIRST;
            end
        end else if (!w_active || i_abort) begin
            // Unused codes fall back to IDLE just like an abort.
            w_state_d = ST_IDLE;
        end else if (w_in_cur && (r_deb_cnt == DEB_LAST)) begin
            w_state_d = w_next_cur;
            w_done_d  = (w_next_cur == ST_IDLE);
        end else if ((w_tmo_cur != '0) && (r_tmo_cnt == w_tmo_cur - TW'(1))) begin
            w_state_d   = ST_IDLE;
            w_timeout_d = 1'b1;
        end else begin
            w_deb_cnt_d = w_in_cur ? r_deb_cnt + DW'(1) : '0;
            w_tmo_cnt_d = (r_tmo_cnt == TMO_SAT) ? r_tmo_cnt : r_tmo_cnt + TW'(1);
        end
    end

    // Output decode: one-hot of the upcoming state, registered alongside it.
    always_comb begin
        w_out_d = '0;
        for (int unsigned k = 1; k <= N_STATES; k++) begin
            w_out_d[k-1] = (w_state_d == SW'(k));
        end
    end

    assign o_out_state = r_state;
    assign o_out       = r_out;
    assign o_busy      = (r_state != ST_IDLE);
    assign o_done      = r_done;
    assign o_timeout   = r_timeout;
    assign o_cfg_err   = r_cfg_err;

endmodule

// File: tb/tb_prog_seq_fsm.sv
// Directed self-checking bench for prog_seq_fsm with default parameters (5 states, DEB=2).
module tb_prog_seq_fsm;

    localparam int unsigned N_STATES = 5;
    localparam int unsigned SW       = 4;
    localparam int unsigned TW       = 8;
    localparam int unsigned DEB      = 2;

    logic                i_clk;
    logic                i_rst_n;
    logic                i_cfg_we;
    logic [SW-1:0]       i_cfg_addr;
    logic [SW-1:0]       i_cfg_next;
    logic [TW-1:0]       i_cfg_tmo;
    logic                i_ok;
    logic                i_abort;
    logic [N_STATES-1:0] i_in;
    logic [SW-1:0]       o_out_state;
    logic [N_STATES-1:0] o_out;
    logic                o_busy;
    logic                o_done;
    logic                o_timeout;
    logic                o_cfg_err;

    int n_checks = 0;
    int n_fail   = 0;

    prog_seq_fsm #(
        .N_STATES (N_STATES),
        .SW       (SW),
        .TW       (TW),
        .DEB      (DEB)
    ) u_dut (
        .i_clk       (i_clk),
        .i_rst_n     (i_rst_n),
        .i_cfg_we    (i_cfg_we),
        .i_cfg_addr  (i_cfg_addr),
        .i_cfg_next  (i_cfg_next),
        .i_cfg_tmo   (i_cfg_tmo),
        .i_ok        (i_ok),
        .i_abort     (i_abort),
        .i_in        (i_in),
        .o_out_state (o_out_state),
        .o_out       (o_out),
        .o_busy      (o_busy),
        .o_done      (o_done),
        .o_timeout   (o_timeout),
        .o_cfg_err   (o_cfg_err)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic cfg_write(input logic [SW-1:0] addr, input logic [SW-1:0] nxt,
                             input logic [TW-1:0] tmo);
        i_cfg_we   = 1'b1;
        i_cfg_addr = addr;
        i_cfg_next = nxt;
        i_cfg_tmo  = tmo;
        tick();
        i_cfg_we   = 1'b0;
    endtask

    task automatic start();
        i_ok = 1'b1;
        tick();
        i_ok = 1'b0;
    endtask

    task automatic do_abort();
        i_abort = 1'b1;
        tick();
        i_abort = 1'b0;
    endtask

    // Hold one request bit for DEB cycles, then release.
    task automatic advance(input int unsigned bitn);
        i_in = '0;
        i_in[bitn] = 1'b1;
        repeat (DEB) tick();
        i_in = '0;
    endtask

    logic [N_STATES-1:0] exp_out;

    initial begin
        i_rst_n    = 1'b1;
        i_cfg_we   = 1'b0;
        i_cfg_addr = '0;
        i_cfg_next = '0;
        i_cfg_tmo  = '0;
        i_ok       = 1'b0;
        i_abort    = 1'b0;
        i_in       = '0;
        #1 i_rst_n = 1'b0;
        repeat (2) tick();
        check("rst_state", 32'(o_out_state), 32'h0);
        check("rst_out", 32'(o_out), 32'h0);
        check("rst_flags", {o_busy, o_done, o_timeout, o_cfg_err}, 32'h0);
        i_rst_n = 1'b1;
        tick();

        // Default ring walk 1..5 then wrap to 1.
        start();
        check("ring_start_out", 32'(o_out), 32'h01);
        check("ring_busy", 32'(o_busy), 32'h1);
        for (int k = 0; k < 5; k++) begin
            i_in = 5'(1 << k);
            tick();
            check("ring_deb_hold", 32'(o_out_state), 32'(k + 1));
            tick();
            i_in = '0;
            exp_out = 5'(1 << ((k + 1) % 5));
            check("ring_out", 32'(o_out), 32'(exp_out));
            check("ring_state", 32'(o_out_state), 32'(((k + 1) % 5) + 1));
            check("ring_done", 32'(o_done), 32'h0);
        end
        do_abort();
        check("ring_abort_state", 32'(o_out_state), 32'h0);

        // next[3]=0, next[1]=3: 1 -> 3 -> IDLE with done.
        cfg_write(4'd3, 4'd0, 8'd0);
        check("cfg_ok_noerr", 32'(o_cfg_err), 32'h0);
        cfg_write(4'd1, 4'd3, 8'd0);
        start();
        advance(0);
        check("fin_state3", 32'(o_out_state), 32'h3);
        check("fin_out3", 32'(o_out), 32'h04);
        advance(2);
        check("fin_done", 32'(o_done), 32'h1);
        check("fin_idle", {28'h0, o_out_state}, 32'h0);
        check("fin_busy", 32'(o_busy), 32'h0);
        check("fin_out0", 32'(o_out), 32'h0);
        check("fin_no_tmo", 32'(o_timeout), 32'h0);
        tick();
        check("fin_done_pulse", 32'(o_done), 32'h0);

        // tmo[1]=10: state 1 for exactly 10 cycles.
        cfg_write(4'd1, 4'd3, 8'd10);
        start();
        repeat (9) tick();
        check("tmo_still1", 32'(o_out_state), 32'h1);
        check("tmo_not_yet", 32'(o_timeout), 32'h0);
        tick();
        check("tmo_idle", 32'(o_out_state), 32'h0);
        check("tmo_pulse", 32'(o_timeout), 32'h1);
        check("tmo_no_done", 32'(o_done), 32'h0);
        tick();
        check("tmo_pulse_end", 32'(o_timeout), 32'h0);

        // tmo[1]=3 with advance landing on the expiry edge: advance wins.
        cfg_write(4'd1, 4'd2, 8'd3);
        start();
        tick();
        i_in = 5'b00001;
        tick();
        check("race_pre", 32'(o_out_state), 32'h1);
        tick();
        i_in = '0;
        check("race_state2", 32'(o_out_state), 32'h2);
        check("race_no_tmo", 32'(o_timeout), 32'h0);
        check("race_no_done", 32'(o_done), 32'h0);

        // Write while busy is rejected.
        cfg_write(4'd2, 4'd4, 8'd0);
        check("busy_cfg_err", 32'(o_cfg_err), 32'h1);
        check("busy_cfg_state", 32'(o_out_state), 32'h2);
        tick();
        check("busy_cfg_err_end", 32'(o_cfg_err), 32'h0);
        do_abort();

        // Walk to 3 (next[2] must still be 3), then abort.
        start();
        advance(0);
        advance(1);
        check("abort_pre3", 32'(o_out_state), 32'h3);
        do_abort();
        check("abort_idle", 32'(o_out_state), 32'h0);
        check("abort_out", 32'(o_out), 32'h0);
        check("abort_done", 32'(o_done), 32'h0);
        check("abort_busy", 32'(o_busy), 32'h0);

        // Idle writes with bad address / bad next.
        cfg_write(4'd0, 4'd1, 8'd0);
        check("bad_addr0", 32'(o_cfg_err), 32'h1);
        cfg_write(4'd2, 4'd7, 8'd0);
        check("bad_next7", 32'(o_cfg_err), 32'h1);
        cfg_write(4'd6, 4'd1, 8'd0);
        check("bad_addr6", 32'(o_cfg_err), 32'h1);

        // Reset mid-sequence restores the defaults.
        cfg_write(4'd1, 4'd4, 8'd0);
        start();
        advance(0);
        check("rst_pre4", 32'(o_out_state), 32'h4);
        i_rst_n = 1'b0;
        #1;
        check("mid_rst_state", 32'(o_out_state), 32'h0);
        check("mid_rst_out", 32'(o_out), 32'h0);
        check("mid_rst_flags", {o_busy, o_done, o_timeout, o_cfg_err}, 32'h0);
        #3 i_rst_n = 1'b1;
        tick();
        start();
        // Foreign request bits are ignored.
        i_in = 5'b11110;
        repeat (3) tick();
        check("ignore_other_in", 32'(o_out_state), 32'h1);
        advance(0);
        check("default_restored", 32'(o_out_state), 32'h2);
        check("default_out", 32'(o_out), 32'h02);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

endmodule
